// File: rtl/carry_select_adder_16bit.sv
// 16-bit carry-select adder built from 4-bit ripple-carry blocks.
// The sum and carry-out are registered, so each result appears one clock after its operands.

module csa_full_adder (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic s,
    output logic co
);
    logic p;

    always_comb begin
        p  = x ^ y;
        s  = p ^ c;
        co = (x & y) | (c & p);
    end
endmodule

module csa_rca4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);
    logic [4:0] c;

    assign c[0]  = c_in;
    assign c_out = c[4];

    for (genvar i = 0; i < 4; i++) begin : g_bit
        csa_full_adder u_fa (
            .x  (x[i]),
            .y  (y[i]),
            .c  (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end
endmodule

// The sum is precomputed for carry-in 0 and for carry-in 1; the real incoming carry picks one.
module csa_select_block (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c_sel,
    output logic [3:0] s,
    output logic       c_out
);
    logic [3:0] s0;
    logic [3:0] s1;
    logic       c0;
    logic       c1;

    csa_rca4 u_rca_c0 (
        .x     (x),
        .y     (y),
        .c_in  (1'b0),
        .s     (s0),
        .c_out (c0)
    );

    csa_rca4 u_rca_c1 (
        .x     (x),
        .y     (y),
        .c_in  (1'b1),
        .s     (s1),
        .c_out (c1)
    );

    always_comb begin
        s     = c_sel ? s1 : s0;
        c_out = c_sel ? c1 : c0;
    end
endmodule

module carry_select_adder_16bit #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NUM_BLK = WIDTH / BLOCK;

    logic [NUM_BLK:0] blk_c;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_d;
    logic             cout_q;

    assign blk_c[0] = cin;

    csa_rca4 u_blk0 (
        .x     (a[BLOCK-1:0]),
        .y     (b[BLOCK-1:0]),
        .c_in  (blk_c[0]),
        .s     (sum_d[BLOCK-1:0]),
        .c_out (blk_c[1])
    );

    for (genvar k = 1; k < NUM_BLK; k++) begin : g_blk
        csa_select_block u_sel (
            .x     (a[k*BLOCK +: BLOCK]),
            .y     (b[k*BLOCK +: BLOCK]),
            .c_sel (blk_c[k]),
            .s     (sum_d[k*BLOCK +: BLOCK]),
            .c_out (blk_c[k+1])
        );
    end

    always_comb begin
        cout_d = blk_c[NUM_BLK];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_carry_select_adder_16bit.sv
// Self-checking bench for carry_select_adder_16bit.
// The reference result is a plain 17-bit sum of the inputs, checked one clock after the inputs are applied.

module tb_carry_select_adder_16bit;
    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;

    int n_cmp  = 0;
    int n_fail = 0;

    carry_select_adder_16bit dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] ref_add(input logic [15:0] va, input logic [15:0] vb,
                                            input logic vc);
        return 17'(va) + 17'(vb) + 17'(vc);
    endfunction

    task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        @(negedge clk);
        a   = va;
        b   = vb;
        cin = vc;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a = 16'd2; b = 16'd2; cin = 1'b1;
        #1;
        n_cmp++;
        if ({cout, sum} !== 17'h0) begin
            $display("FAIL reset_initial: got %h required 00000", {cout, sum});
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        n_cmp++;
        if ({cout, sum} !== 17'd5) begin
            $display("FAIL reset_release_load: got %h required 00005", {cout, sum});
            n_fail++;
        end
        // Assert reset between edges: outputs must clear without waiting for a clock.
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({cout, sum} !== 17'h0) begin
            $display("FAIL reset_async: got %h required 00000", {cout, sum});
            n_fail++;
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({cout, sum} !== 17'h0) begin
                $display("FAIL reset_hold[%0d]: got %h required 00000", i, {cout, sum});
                n_fail++;
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [15:0] ta [5] = '{16'd0, 16'd2, 16'd2, 16'd100, 16'd12};
        logic [15:0] tb [5] = '{16'd0, 16'd2, 16'd4, 16'd0,   16'd3};
        logic        tc [5] = '{1'b0,  1'b1,  1'b1,  1'b0,    1'b1};
        logic [16:0] te [5] = '{17'd0, 17'd5, 17'd7, 17'd100, 17'd16};
        for (int i = 0; i < 5; i++) begin
            drive(ta[i], tb[i], tc[i]);
            step();
            n_cmp++;
            if ({cout, sum} !== te[i]) begin
                $display("FAIL basic[%0d]: got %h required %h", i, {cout, sum}, te[i]);
                n_fail++;
            end
        end
    endtask

    task automatic test_carry_chain;
        drive(16'hFFFF, 16'h0000, 1'b1);
        step();
        n_cmp++;
        if ({cout, sum} !== 17'h1_0000) begin
            $display("FAIL chain_ffff_cin: got %h required 10000", {cout, sum});
            n_fail++;
        end
        drive(16'h0FFF, 16'h0001, 1'b0);
        step();
        n_cmp++;
        if ({cout, sum} !== 17'h0_1000) begin
            $display("FAIL chain_0fff: got %h required 01000", {cout, sum});
            n_fail++;
        end
    endtask

    task automatic test_block_boundary;
        drive(16'h000F, 16'h0001, 1'b0);
        step();
        n_cmp++;
        if ({cout, sum} !== 17'h0_0010) begin
            $display("FAIL boundary_blk1: got %h required 00010", {cout, sum});
            n_fail++;
        end
        drive(16'h00FF, 16'h0000, 1'b1);
        step();
        n_cmp++;
        if ({cout, sum} !== 17'h0_0100) begin
            $display("FAIL boundary_blk2: got %h required 00100", {cout, sum});
            n_fail++;
        end
    endtask

    task automatic test_max;
        drive(16'hFFFF, 16'hFFFF, 1'b1);
        step();
        n_cmp++;
        if ({cout, sum} !== 17'h1_FFFF) begin
            $display("FAIL max_all_ones: got %h required 1ffff", {cout, sum});
            n_fail++;
        end
        drive(16'h8000, 16'h8000, 1'b0);
        step();
        n_cmp++;
        if ({cout, sum} !== 17'h1_0000) begin
            $display("FAIL max_msb: got %h required 10000", {cout, sum});
            n_fail++;
        end
        drive(16'h0000, 16'h0000, 1'b0);
        step();
        n_cmp++;
        if ({cout, sum} !== 17'h0) begin
            $display("FAIL all_zero: got %h required 00000", {cout, sum});
            n_fail++;
        end
    endtask

    task automatic test_reset_midstream;
        logic [16:0] exp;
        drive(16'h1234, 16'h4321, 1'b0);
        step();
        n_cmp++;
        if ({cout, sum} !== 17'h0_5555) begin
            $display("FAIL mid_before: got %h required 05555", {cout, sum});
            n_fail++;
        end
        drive(16'hA5A5, 16'h5A5B, 1'b0);
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({cout, sum} !== 17'h0) begin
            $display("FAIL mid_async_clear: got %h required 00000", {cout, sum});
            n_fail++;
        end
        #1 rst = 1'b0;
        a = 16'hC000; b = 16'h4001; cin = 1'b1;
        exp = ref_add(16'hC000, 16'h4001, 1'b1);
        step();
        n_cmp++;
        if ({cout, sum} !== exp) begin
            $display("FAIL mid_first_after_release: got %h required %h", {cout, sum}, exp);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back_random;
        logic [16:0] exp_q[$];
        logic [16:0] exp;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            drive(ra, rb, rc);
            exp_q.push_back(ref_add(ra, rb, rc));
            // Inputs wiggling after the edge must not disturb the captured result.
            step();
            exp = exp_q.pop_front();
            n_cmp++;
            if ({cout, sum} !== exp) begin
                $display("FAIL random[%0d]: a=%h b=%h cin=%b got %h required %h",
                         i, ra, rb, rc, {cout, sum}, exp);
                n_fail++;
            end
            a = ~ra;
            b = ~rb;
            cin = ~rc;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_block_boundary();
        test_max();
        test_reset_midstream();
        test_back_to_back_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/carry_select_adder_16bit.md
Name: carry_select_adder_16bit

Overview:
- 16-bit unsigned adder with carry-in, built as a carry-select structure of 4-bit ripple-carry blocks.
- Each upper block precomputes its result for both carry-in values; the real block carry selects one.
- Sum and carry-out are registered, giving one clock of latency.
- Used as a fast arithmetic leaf inside datapaths that need a registered add result.

Parameters:
- WIDTH, 16, operand and sum width. Fixed at 16 for this block; the block is not required to support other values.
- BLOCK, 4, bits per carry-select block. WIDTH/BLOCK = 4 blocks.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- a  input  16  operand A, unsigned.
- b  input  16  operand B, unsigned.
- cin  input  1  carry-in.
- sum  output  16  registered (a + b + cin) mod 2^16.
- cout  output  1  registered carry-out, bit 16 of a + b + cin.

Behaviour:
- One clock, one asynchronous active-high reset. When rst is asserted, sum = 16'h0000 and cout = 0 immediately, independent of clk, and they stay there while rst is high.
- Datapath, combinational from a, b, cin:
  - Block 0 (bits 3:0) is a single 4-bit ripple-carry adder using cin.
  - Blocks 1..3 (bits 7:4, 11:8, 15:12) each contain two 4-bit ripple-carry adders, one with carry-in 0 and one with carry-in 1.
  - A 2:1 mux, steered by the previous block's selected carry-out, picks that block's 4-bit sum and carry-out.
  - The carry-out of block 3 is the result carry.
- Each full-adder cell: s = x ^ y ^ c; co = (x & y) | (c & (x ^ y)).
- Register stage: on every rising clk edge with rst low, sum <= combinational sum and cout <= combinational carry. No enable; the result is captured every cycle.
- Latency: inputs applied before edge N appear on the outputs after edge N. Throughput is one add per cycle.
- Arithmetic: {cout, sum} == a + b + cin exactly, as a 17-bit unsigned result. Wrap-around modulo 2^16 on sum; the overflow shows only on cout.
- Boundary cases:
  - a = b = 16'hFFFF, cin = 1 gives {cout, sum} = 17'h1_FFFF.
  - 16'hFFFF + 0 + cin=1 gives sum = 0, cout = 1.
  - All-zero inputs give 0 / 0.
- Reset mid-operation: asserting rst clears outputs immediately. After deassertion, the first rising edge loads the current inputs with no extra warm-up cycle.
- Inputs that change between edges have no effect until the next edge. The combinational core must settle within one cycle at the target clock.
- No X-propagation masking: known inputs must always yield known outputs after one edge.

Test Plan:
- Reset: assert rst with a=16'd2, b=16'd2, cin=1 -> sum=0, cout=0 asynchronously, held through clock edges while rst=1.
- Basic adds, one per cycle, checked one edge later:
  - 0+0+0 -> sum 0, cout 0.
  - 2+2+1 -> 5, cout 0.
  - 2+4+1 -> 7, cout 0.
  - 100+0+0 -> 100, cout 0.
  - 12+3+1 -> 16, cout 0.
- Carry chain across all blocks: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1. Also a=16'h0FFF, b=16'h0001, cin=0 -> sum=16'h1000, cout=0.
- Block-boundary select: a=16'h000F, b=16'h0001, cin=0 -> sum=16'h0010. a=16'h00FF, b=16'h0000, cin=1 -> sum=16'h0100. Both with cout=0.
- Maximum: a=b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1. a=b=16'h8000, cin=0 -> sum=0, cout=1.
- Reset mid-stream plus random check: pulse rst between two edges during back-to-back adds -> outputs go to 0 immediately, and the next edge after release shows the current inputs' result. Then run 1000 random (a, b, cin) vectors and compare {cout, sum} against a + b + cin delayed by one cycle.
